// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared MDUOp encodings, latency defaults and the divide helper
package e_mdu_pkg;

    localparam logic [3:0] MDU_NOP   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    // Returns {remainder, quotient}. Signed division is done on magnitudes so
    // 0x80000000 / -1 wraps to 0x80000000 instead of trapping; the quotient
    // truncates toward zero and the remainder follows the dividend's sign.
    function automatic logic [63:0] divmod(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic        na, nb;
        logic [31:0] ma, mb, q, r;
        na = sgn & a[31];
        nb = sgn & b[31];
        ma = na ? -a : a;
        mb = nb ? -b : b;
        q  = (mb == '0) ? '0 : ma / mb;
        r  = (mb == '0) ? '0 : ma % mb;
        return {na ? -r : r, (na ^ nb) ? -q : q};
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage operand/opcode bus into the MDU and its result/status bus out
interface e_mdu_if;

    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        Req;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDURead;

    modport master (
        output A, B, MDUOp, Req,
        input  Start, Busy, HI, LO, MDURead
    );

    modport slave (
        input  A, B, MDUOp, Req,
        output Start, Busy, HI, LO, MDURead
    );

endinterface

// File: rtl/e_mdu.sv
// e_mdu: E-stage multi-cycle multiply/divide unit owning the HI/LO registers
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input logic   CLK,
    input logic   RESET,
    e_mdu_if.slave bus
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic [31:0]   tmp_hi, tmp_lo, hi, lo;
    logic          dz;
    logic          is_mul, is_div, busy, start, div_zero;
    logic [63:0]   prod, qr;

    assign is_mul   = (bus.MDUOp == MDU_MULT) || (bus.MDUOp == MDU_MULTU);
    assign is_div   = (bus.MDUOp == MDU_DIV) || (bus.MDUOp == MDU_DIVU);
    assign div_zero = is_div && (bus.B == '0);
    assign busy     = (cnt != '0);
    assign start    = (is_mul || is_div) && !bus.Req && !busy;

    // Full-width product and quotient/remainder, evaluated every cycle and captured only on start
    always_comb begin
        prod = (bus.MDUOp == MDU_MULT)
             ? $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B})
             : {32'b0, bus.A} * {32'b0, bus.B};
        qr   = divmod(bus.A, bus.B, bus.MDUOp == MDU_DIV);
    end

    // Latency countdown, result staging, commit on the last busy edge, and MTHI/MTLO writes
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt    <= '0;
            tmp_hi <= '0;
            tmp_lo <= '0;
            hi     <= '0;
            lo     <= '0;
            dz     <= 1'b0;
        end else begin
            if (start) begin
                cnt <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                dz  <= div_zero;
                if (!div_zero)
                    {tmp_hi, tmp_lo} <= is_mul ? prod : qr;
            end else if (cnt > CW'(1)) begin
                cnt <= cnt - 1'b1;
            end else if (cnt == CW'(1)) begin
                cnt <= '0;
                if (!dz)
                    {hi, lo} <= {tmp_hi, tmp_lo};
            end
            if (!bus.Req && !busy && bus.MDUOp == MDU_MTHI)
                hi <= bus.A;
            if (!bus.Req && !busy && bus.MDUOp == MDU_MTLO)
                lo <= bus.A;
        end
    end

    assign bus.Start   = start;
    assign bus.Busy    = busy;
    assign bus.HI      = hi;
    assign bus.LO      = lo;
    assign bus.MDURead = (bus.MDUOp == MDU_MFHI) ? hi : (bus.MDUOp == MDU_MFLO) ? lo : '0;

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit of the E stage in the 5-stage MIPS pipeline.
- Consumes the two source operands that the decode-stage register file produces, after they pass through the D/E register and forwarding muxes.
- Executes mult/multu/div/divu with a fixed multi-cycle latency, holds the HI/LO architectural registers, and serves mfhi/mflo/mthi/mtlo.
- Exports Busy to the hazard unit, which stalls D when an MDU instruction meets Busy or Start.

Parameters:
- MULT_CYCLES, 5, Busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, Busy duration in cycles for div/divu.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- A  in  32  operand rs (forwarded E-stage value).
- B  in  32  operand rt (forwarded E-stage value).
- MDUOp  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NOP.
- Req  in  1  interrupt/exception request this cycle; cancels the E-stage MDU instruction.
- Start  out  1  combinational: MDUOp in 1..4 and !Req and !Busy.
- Busy  out  1  registered: operation in flight.
- HI  out  32  current HI register.
- LO  out  32  current LO register.
- MDURead  out  32  combinational: HI if MDUOp==MFHI, LO if MDUOp==MFLO, else 0.

Behaviour:
- Reset is asynchronous active-high. While RESET=1, HI, LO, cnt, tmpHI and tmpLO are all 0. Outputs: Busy=0, HI=0, LO=0.
- State is a down-counter cnt, width $clog2(DIV_CYCLES+1). Busy = (cnt != 0), decoded from the register with no combinational path from inputs.
- Start accepted at edge:
  - MULT: {tmpHI,tmpLO} <= signed A*B (64-bit).
  - MULTU: {tmpHI,tmpLO} <= unsigned A*B.
  - DIV: tmpLO <= signed A/B; tmpHI <= signed A%B. Quotient truncates toward zero; remainder takes the sign of A.
  - DIVU: unsigned quotient and remainder.
  - cnt <= MULT_CYCLES for mult ops, DIV_CYCLES for div ops.
  - Busy rises the cycle after the Start edge and stays high for exactly MULT_CYCLES or DIV_CYCLES cycles.
- Operands are sampled only at the Start edge. Later changes to A/B during Busy have no effect.
- When cnt > 1: cnt <= cnt-1.
- When cnt == 1: cnt <= 0 and HI <= tmpHI, LO <= tmpLO on that same edge. The new values are visible in the first cycle with Busy=0.
- Divide by zero (DIV/DIVU with B==0):
  - full DIV_CYCLES Busy period still runs;
  - commit is suppressed, so HI/LO keep their prior values;
  - tmp registers are unused.
- Signed overflow case DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: HI <= A or LO <= A at the edge, only when !Req and !Busy. Otherwise ignored; the hazard unit guarantees it never reaches E while Busy.
- Req=1 in a cycle:
  - Start is forced to 0 and MTHI/MTLO writes are suppressed, so the victim instruction leaves no trace.
  - An operation already in flight (cnt != 0) continues and commits normally; it belongs to an older, retired instruction.
- Start while Busy=1 is ignored; cnt and tmp registers are untouched.
- Completion edge with a simultaneous new Start is impossible by construction, since Start requires !Busy and Busy is high through that edge.
- MDURead is independent of Req and Busy. The hazard unit must stall MFHI/MFLO while Busy.
- RESET asserted mid-operation aborts immediately: cnt=0, HI=LO=0, no commit after release.

Decomposition:
- Shared package/header holds:
  - MDUOp encodings MDU_NOP..MDU_MTLO (4-bit constants);
  - defaults MULT_CYCLES and DIV_CYCLES, so the hazard unit decodes the same values.
- No sub-module is needed; the multiply/divide operators are inferred inline.
- An optional e_mdu_div helper (combinational quotient/remainder with the sign rules above) is acceptable but not required.

Test Plan:
- MULT, A=0xFFFFFFFD (-3), B=5 -> Start=1; Busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU, A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; HI/LO unchanged during Busy.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, A=7, B=0, with prior HI=0x11, LO=0x22 -> Busy 10 cycles; HI=0x11, LO=0x22 afterward.
- MTHI A=0x1234 with Req=1 -> HI unchanged, Start=0. Same op with Req=0 -> HI=0x1234; MFHI gives MDURead=0x1234.
- MULT started, then Req=1 on cycle 2 -> commit still occurs. Repeat and pulse RESET on cycle 3 -> Busy=0, HI=LO=0 immediately, no later commit.
